// File: rtl/rx_pkg.sv
// rx_pkg: shared types for the UART receive path.
//   parity_mode_e : parity option of the receiver (none / even / odd)
//   rx_state_e    : receive FSM states
//   majority3     : 2-of-3 vote used when sampling the line
package rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sample_voter.sv
// rx_sample_voter: three-sample majority vote across the middle of a bit.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   tick        : oversample strobe
//   tick_idx    : position of the current tick inside the bit period
//   sample      : synchronised line value
//   vote_valid  : high on the tick that carries the third sample
//   vote_bit    : majority of the two stored samples and the live one
module rx_sample_voter
  import rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [CNT_W-1:0] tick_idx,
  input  logic             sample,
  output logic             vote_valid,
  output logic             vote_bit
);

  localparam logic [CNT_W-1:0] IDX_A = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] IDX_B = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] IDX_C = CNT_W'(OVERSAMPLE / 2 + 1);

  logic sample_a;
  logic sample_b;

  // Capture the first two of the three mid-bit samples; the third is
  // taken live so the vote is available on the very tick it is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_a <= 1'b1;
      sample_b <= 1'b1;
    end else if (tick) begin
      if (tick_idx == IDX_A) sample_a <= sample;
      if (tick_idx == IDX_B) sample_b <= sample;
    end
  end

  assign vote_valid = tick && (tick_idx == IDX_C);
  assign vote_bit   = majority3(sample_a, sample_b, sample);

endmodule

// File: rtl/rx_frame_control.sv
// rx_frame_control: oversampled UART receiver with a one-word holding register.
// Ports:
//   CLK, RST     : clock and synchronous active-high reset
//   BAUD_TICK    : one-cycle strobe at OVERSAMPLE x baud rate
//   RXD          : asynchronous serial input, idle high
//   RXACK        : consumer pops the holding register
//   RXDATA       : held word, LSB was first on the line
//   RXRDY        : holding register valid
//   RXEN         : frame in progress
//   PARITY_ERR   : parity mismatch on the held word
//   FRAME_ERR    : a stop bit of the held word was low
//   OVERRUN_ERR  : a word was overwritten before being acknowledged
module rx_frame_control
  import rx_pkg::*;
#(
  parameter int           DATA_BITS   = 8,
  parameter int           OVERSAMPLE  = 16,
  parameter parity_mode_e PARITY_MODE = PAR_NONE,
  parameter int           STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BAUD_TICK,
  input  logic                 RXD,
  input  logic                 RXACK,
  output logic [DATA_BITS-1:0] RXDATA,
  output logic                 RXRDY,
  output logic                 RXEN,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN_ERR
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_INVERT = (PARITY_MODE == PAR_ODD);

  rx_state_e            state;
  logic                 sync_meta;
  logic                 sync_line;
  logic                 armed;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_val;
  logic                 parity_bad;
  logic                 frame_bad;
  logic                 vote_valid;
  logic                 vote_bit;
  logic                 bit_end;
  logic                 commit;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
    end else begin
      sync_meta <= RXD;
      sync_line <= sync_meta;
    end
  end

  rx_sample_voter #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (TICK_W)
  ) u_voter (
    .clk        (CLK),
    .rst        (RST),
    .tick       (BAUD_TICK),
    .tick_idx   (tick_cnt),
    .sample     (sync_line),
    .vote_valid (vote_valid),
    .vote_bit   (vote_bit)
  );

  // A bit period ends on its last tick; the frame commits at the end of
  // the final stop bit, which is also where the FSM drops back to IDLE.
  always_comb begin
    bit_end = BAUD_TICK && (tick_cnt == LAST_TICK);
    commit  = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  end

  // Receive FSM. 'armed' records that the line has been seen high while
  // idle or in a stop bit, so a start needs a genuine high-to-low change.
  // That keeps a held break from retriggering and still lets a start bit
  // that begins right at the stop-bit boundary be caught in the first
  // IDLE cycle after commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      bit_val    <= 1'b1;
      parity_bad <= 1'b0;
      frame_bad  <= 1'b0;
      armed      <= 1'b0;
    end else begin
      if (BAUD_TICK && (state != IDLE))
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
      if (vote_valid && (state != IDLE))
        bit_val <= vote_bit;
      if (sync_line && ((state == IDLE) || (state == STOP)))
        armed <= 1'b1;

      unique case (state)
        IDLE: begin
          if (armed && !sync_line) begin
            state      <= START;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            armed      <= 1'b0;
            parity_bad <= 1'b0;
            frame_bad  <= 1'b0;
          end
        end
        START: begin
          if (vote_valid && vote_bit) begin
            state    <= IDLE;
            tick_cnt <= '0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            parity_bad <= (bit_val != ((^shift_reg) ^ PAR_INVERT));
            state      <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!bit_val) frame_bad <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register. A commit always wins over an acknowledge in the same
  // cycle: the new word is loaded, RXRDY stays set and OVERRUN_ERR is only
  // raised when the old word was still unread and not being popped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RXDATA      <= '0;
      RXRDY       <= 1'b0;
      PARITY_ERR  <= 1'b0;
      FRAME_ERR   <= 1'b0;
      OVERRUN_ERR <= 1'b0;
    end else if (commit) begin
      RXDATA     <= shift_reg;
      PARITY_ERR <= parity_bad;
      FRAME_ERR  <= frame_bad | ~bit_val;
      RXRDY      <= 1'b1;
      if (RXRDY && !RXACK) OVERRUN_ERR <= 1'b1;
    end else if (RXACK && RXRDY) begin
      RXRDY       <= 1'b0;
      OVERRUN_ERR <= 1'b0;
    end
  end

  assign RXEN = (state != IDLE);

endmodule
